// File: rtl/putc_tx_ctrl.sv
// CPU putc byte queue feeding uart_sender through its go/ready handshake.
// Optional PUTC_CRLF_EN expands each accepted 0x0A into 0x0D,0x0A.
module putc_tx_ctrl #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  putc_valid,
    input  logic [DATA_W-1:0]     putc_data,
    output logic                  putc_stall,
    input  logic                  uart_ready,
    output logic                  uart_go,
    output logic [DATA_W-1:0]     uart_data,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic                  busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LAUNCH  = 2'd1;
    localparam logic [1:0] S_WAIT_LO = 2'd2;
    localparam logic [1:0] S_WAIT_HI = 2'd3;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     push_n;
    logic [1:0]        state_q, state_d;
    logic              go_q, go_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovf_q, ovf_d;
    logic              push, pop;

`ifdef PUTC_CRLF_EN
    localparam logic [DATA_W-1:0] LF = DATA_W'(8'h0A);
    localparam logic [DATA_W-1:0] CR = DATA_W'(8'h0D);

    logic is_lf;

    // A line feed needs two free slots, so it stalls one entry early.
    assign is_lf      = (putc_data == LF);
    assign putc_stall = is_lf ? (count_q >= FULL - CW'(1))
                              : (count_q == FULL);
    assign push       = putc_valid && !putc_stall;
    assign push_n     = !push ? CW'(0) : (is_lf ? CW'(2) : CW'(1));

    always_ff @(posedge clk) begin
        if (push) begin
            if (is_lf) begin
                mem_q[wr_ptr_q]            <= CR;
                mem_q[wr_ptr_q + PW'(1)]   <= LF;
            end else begin
                mem_q[wr_ptr_q]            <= putc_data;
            end
        end
    end
`else
    assign putc_stall = (count_q == FULL);
    assign push       = putc_valid && !putc_stall;
    assign push_n     = push ? CW'(1) : CW'(0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= putc_data;
        end
    end
`endif

    assign pop = (state_q == S_LAUNCH);

    assign wr_ptr_d = wr_ptr_q + push_n[PW-1:0];
    assign rd_ptr_d = rd_ptr_q + PW'(pop);
    assign count_d  = count_q + push_n - CW'(pop);
    assign ovf_d    = ovf_q | (putc_valid & putc_stall);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (count_q != '0 && uart_ready) state_d = S_LAUNCH;
            S_LAUNCH:  state_d = S_WAIT_LO;
            S_WAIT_LO: if (!uart_ready) state_d = S_WAIT_HI;
            S_WAIT_HI: if (uart_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Head is stable on entry to LAUNCH: no pop can coincide with that edge.
    assign go_d   = (state_d == S_LAUNCH);
    assign data_d = go_d ? mem_q[rd_ptr_q] : data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            go_q     <= 1'b0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            go_q     <= go_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
        end
    end

    assign uart_go    = go_q;
    assign uart_data  = data_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign busy       = (count_q != '0) || (state_q != S_IDLE);

endmodule
